// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bundle for one pipe_stage_buf: the upstream (i_*) and downstream (o_*) sides.
// The buffer takes the slave view; the driving environment takes the master view.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 64
);
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer: DEPTH-entry circular queue with optional
// same-cycle bypass when empty and a synchronous flush for redirects.
module pipe_stage_buf #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter bit PASSTHRU = 1'b0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, bypass, push, pop;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count_q == '0);
    assign bus.i_ready = (count_q != FULL_CNT);
    assign bus.o_valid = (!empty || (PASSTHRU && bus.i_valid)) && !flush;
    assign bus.o_data  = empty ? bus.i_data : mem[rd_ptr_q];
    assign count       = count_q;

    assign bypass = PASSTHRU && empty && bus.i_valid && bus.o_ready && !flush;
    assign push   = bus.i_valid && bus.i_ready && !bypass && !flush;
    assign pop    = bus.o_valid && bus.o_ready && !bypass;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.i_data;
    end

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.o_valid && bus.o_ready && empty) |-> bypass);

    a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.i_valid && !bus.i_ready && !flush) |=> ($stable(bus.i_data) || flush));
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed-vector and reference-queue bench for pipe_stage_buf in three
// configurations: DEPTH=2, DEPTH=3, and DEPTH=2 with bypass.
module tb_pipe_stage_buf;
    logic clk;
    logic rst_n;
    logic flush;
    logic [1:0] cnt_a, cnt_c, cnt_p;

    int checks   = 0;
    int failures = 0;

    pipe_stage_buf_if #(.DATA_W(64)) bus_a ();
    pipe_stage_buf_if #(.DATA_W(64)) bus_c ();
    pipe_stage_buf_if #(.DATA_W(64)) bus_p ();

    pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .PASSTHRU(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a), .count(cnt_a)
    );
    pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .PASSTHRU(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_c), .count(cnt_c)
    );
    pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .PASSTHRU(1'b1)) u_pt (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_p), .count(cnt_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        i_valid;
        logic [63:0] i_data;
        logic        o_ready;
        logic        exp_ir;
        logic        exp_ov;
        logic [63:0] exp_od;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [63:0] d, logic ordy,
                                logic ir, logic ov, logic [63:0] od, logic [1:0] cnt);
        vec_t v;
        v.rst_n = r;  v.flush = f;   v.i_valid = iv; v.i_data = d; v.o_ready = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;  v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_p(input string name, input logic ov, input logic [63:0] od,
                           input logic [1:0] cnt);
        check({name, "_ovalid"}, 64'(bus_p.o_valid), 64'(ov));
        if (ov) check({name, "_odata"}, bus_p.o_data, od);
        check({name, "_count"}, 64'(cnt_p), 64'(cnt));
    endtask

    logic [63:0] q[$];
    logic        hold;
    logic        exp_ov, exp_ir;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus_a.i_valid = 1'b0; bus_a.i_data = '0; bus_a.o_ready = 1'b0;
        bus_c.i_valid = 1'b0; bus_c.i_data = '0; bus_c.o_ready = 1'b0;
        bus_p.i_valid = 1'b0; bus_p.i_data = '0; bus_p.o_ready = 1'b0;

        //              rst flu iv data           ordy ir ov od            cnt
        // Fill with o_ready low, hold 0xC while full, then drain in order.
        vecs.push_back(mk(1, 0, 0, 64'h0,        0,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 1, 64'hA,        0,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 1, 64'hB,        0,   1, 1, 64'hA,        2'd1));
        vecs.push_back(mk(1, 0, 1, 64'hC,        0,   0, 1, 64'hA,        2'd2));
        vecs.push_back(mk(1, 0, 1, 64'hC,        0,   0, 1, 64'hA,        2'd2));
        vecs.push_back(mk(1, 0, 1, 64'hC,        1,   0, 1, 64'hA,        2'd2));
        vecs.push_back(mk(1, 0, 1, 64'hC,        1,   1, 1, 64'hB,        2'd1));
        vecs.push_back(mk(1, 0, 0, 64'h0,        1,   1, 1, 64'hC,        2'd1));
        vecs.push_back(mk(1, 0, 0, 64'h0,        1,   1, 0, 64'h0,        2'd0));
        // Flush while full with a pending 0xDEAD; 0x5 emerges first afterwards.
        vecs.push_back(mk(1, 0, 1, 64'h11,       0,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 1, 64'h22,       0,   1, 1, 64'h11,       2'd1));
        vecs.push_back(mk(1, 0, 0, 64'h0,        0,   0, 1, 64'h11,       2'd2));
        vecs.push_back(mk(1, 1, 1, 64'hDEAD,     1,   0, 0, 64'h0,        2'd2));
        vecs.push_back(mk(1, 0, 1, 64'h5,        1,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 0, 64'h0,        1,   1, 1, 64'h5,        2'd1));
        vecs.push_back(mk(1, 0, 0, 64'h0,        0,   1, 0, 64'h0,        2'd0));
        // Flush discards a beat accepted in the same cycle.
        vecs.push_back(mk(1, 1, 1, 64'h77,       0,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 0, 64'h0,        0,   1, 0, 64'h0,        2'd0));
        // Reset with two entries and o_ready high: nothing survives.
        vecs.push_back(mk(1, 0, 1, 64'h31,       0,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 1, 64'h32,       0,   1, 1, 64'h31,       2'd1));
        vecs.push_back(mk(0, 0, 0, 64'h0,        1,   0, 1, 64'h31,       2'd2));
        vecs.push_back(mk(1, 0, 0, 64'h0,        1,   1, 0, 64'h0,        2'd0));
        vecs.push_back(mk(1, 0, 0, 64'h0,        1,   1, 0, 64'h0,        2'd0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            flush         = vecs[i].flush;
            bus_a.i_valid = vecs[i].i_valid;
            bus_a.i_data  = vecs[i].i_data;
            bus_a.o_ready = vecs[i].o_ready;
            #1;
            check($sformatf("vec%0d_iready", i), 64'(bus_a.i_ready), 64'(vecs[i].exp_ir));
            check($sformatf("vec%0d_ovalid", i), 64'(bus_a.o_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_count", i), 64'(cnt_a), 64'(vecs[i].exp_cnt));
            if (vecs[i].exp_ov)
                check($sformatf("vec%0d_odata", i), bus_a.o_data, vecs[i].exp_od);
        end

        // Streaming 0..99 with both sides always ready: one beat per cycle, count stays 1.
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            bus_a.i_valid = (k < 100);
            bus_a.i_data  = 64'(k);
            bus_a.o_ready = 1'b1;
            #1;
            if (k == 0) begin
                check("stream_first_ovalid", 64'(bus_a.o_valid), 64'd0);
                check("stream_first_count", 64'(cnt_a), 64'd0);
            end else begin
                check($sformatf("stream%0d_ovalid", k), 64'(bus_a.o_valid), 64'd1);
                check($sformatf("stream%0d_odata", k), bus_a.o_data, 64'(k - 1));
                check($sformatf("stream%0d_count", k), 64'(cnt_a), 64'd1);
            end
        end
        @(negedge clk);
        bus_a.i_valid = 1'b0;
        #1;
        check("stream_drained_count", 64'(cnt_a), 64'd0);
        bus_a.o_ready = 1'b0;

        // Bypass configuration.
        @(negedge clk);
        bus_p.i_valid = 1'b1; bus_p.i_data = 64'h1234; bus_p.o_ready = 1'b1;
        #1;
        check_p("pt_bypass", 1'b1, 64'h1234, 2'd0);
        @(negedge clk);
        bus_p.i_valid = 1'b0;
        #1;
        check_p("pt_after_bypass", 1'b0, 64'h0, 2'd0);
        @(negedge clk);
        bus_p.i_valid = 1'b1; bus_p.i_data = 64'h55; bus_p.o_ready = 1'b0;
        #1;
        check_p("pt_stall", 1'b1, 64'h55, 2'd0);
        @(negedge clk);
        bus_p.i_data = 64'h66; bus_p.o_ready = 1'b1;
        #1;
        check_p("pt_stored_head", 1'b1, 64'h55, 2'd1);
        @(negedge clk);
        bus_p.i_valid = 1'b0;
        #1;
        check_p("pt_second", 1'b1, 64'h66, 2'd1);
        @(negedge clk);
        flush = 1'b1; bus_p.i_valid = 1'b1; bus_p.i_data = 64'h77;
        #1;
        check_p("pt_flush", 1'b0, 64'h0, 2'd0);
        @(negedge clk);
        flush = 1'b0; bus_p.i_valid = 1'b0; bus_p.o_ready = 1'b0;
        #1;
        check_p("pt_after_flush", 1'b0, 64'h0, 2'd0);

        // DEPTH=3 random traffic against a reference queue.
        hold = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!hold) begin
                bus_c.i_valid = ($urandom_range(0, 3) != 0);
                bus_c.i_data  = {$urandom, $urandom};
            end
            bus_c.o_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ov = (q.size() != 0);
            exp_ir = (q.size() != 3);
            check($sformatf("rand%0d_count", c), 64'(cnt_c), 64'(q.size()));
            check($sformatf("rand%0d_ovalid", c), 64'(bus_c.o_valid), 64'(exp_ov));
            check($sformatf("rand%0d_iready", c), 64'(bus_c.i_ready), 64'(exp_ir));
            if (exp_ov) check($sformatf("rand%0d_odata", c), bus_c.o_data, q[0]);
            if (exp_ov && bus_c.o_ready) void'(q.pop_front());
            if (bus_c.i_valid && exp_ir) q.push_back(bus_c.i_data);
            hold = bus_c.i_valid && !exp_ir;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
